// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter with synchronous parallel load, count
// enable, a registered one-cycle wrap pulse and a sticky invalid-load flag.
// Intended for display, timer and stopwatch datapaths; tc cascades into the
// en input of a higher-order instance, and q feeds seven-segment decoders.
//
// Optional feature macro: BCD_PRESCALE_EN
//   Defined   : a PRESCALE_W-bit prescaler gates steps to one per
//               2**PRESCALE_W enabled, non-load cycles.
//   Undefined : every enabled, non-load edge is a step; PRESCALE_W unused.
//
// Parameters
//   DIGITS      number of BCD digits (1..8)
//   PRESCALE_W  prescaler width (only with BCD_PRESCALE_EN)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active low
//   en    in   count enable
//   up    in   direction: 1 = up, 0 = down
//   load  in   synchronous parallel load (priority over stepping)
//   din   in   load value, digit 0 in bits [3:0]
//   q     out  counter value, digit k in bits [4k+3:4k]
//   tc    out  registered wrap pulse, high for one cycle after a wrapping step
//   err   out  sticky flag: last load contained a digit > 9
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS     = 2,
  parameter int PRESCALE_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  // Reject illegal configurations at elaboration time.
  if (DIGITS < 1 || DIGITS > 8 || PRESCALE_W < 1) begin : g_bad_params
    $error("bcd_updown_counter: DIGITS must be 1..8 and PRESCALE_W >= 1");
  end

  logic [W-1:0]    load_val;   // din with out-of-range digits forced to 0
  logic            load_bad;   // some din digit was > 9
  logic [W-1:0]    step_val;   // q after one up/down step
  logic [DIGITS:0] cy;         // carry (up) / borrow (down) chain
  logic            step;       // this edge performs a count step

  // Load sanitising: any digit above 9 is replaced by 0 and flagged.
  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (din[4*k +: 4] > 4'd9) begin
        load_bad = 1'b1;
      end else begin
        load_val[4*k +: 4] = din[4*k +: 4];
      end
    end
  end

  // Ripple carry/borrow across digits. cy[k] means digit k must move; a digit
  // at its end value (9 going up, 0 going down) rolls over and passes the
  // carry on. cy[DIGITS] set means the whole counter wrapped.
  always_comb begin
    step_val = q;
    cy       = '0;
    cy[0]    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (cy[k]) begin
        if (up) begin
          if (q[4*k +: 4] >= 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
            cy[k+1]            = 1'b1;
          end else begin
            step_val[4*k +: 4] = q[4*k +: 4] + 4'd1;
          end
        end else begin
          if (q[4*k +: 4] == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
            cy[k+1]            = 1'b1;
          end else begin
            step_val[4*k +: 4] = q[4*k +: 4] - 4'd1;
          end
        end
      end
    end
  end

`ifdef BCD_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre;

  // The step fires on the enabled edge where the prescaler rolls from
  // all-ones back to zero.
  assign step = en & ~load & (&pre);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (load) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + 1'b1;
    end
  end
`else
  assign step = en & ~load;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement or process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      tc  <= 1'b0;
      err <= 1'b0;
    end else if (load) begin
      q   <= load_val;
      err <= load_bad;
      tc  <= 1'b0;
    end else if (step) begin
      q   <= step_val;
      tc  <= cy[DIGITS];
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Self-checking bench for bcd_updown_counter (DIGITS = 2, PRESCALE_W = 2).
// The reference model keeps the count as a plain integer modulo 10**DIGITS
// and converts it to BCD only for comparison. Directed sequences cover reset,
// wraps, borrows, invalid loads and load priority; a randomized phase follows.
// Honours BCD_PRESCALE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  localparam int DIGITS = 2;
  localparam int PW     = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         en   = 1'b0;
  logic         up   = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din  = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         err;

  bcd_updown_counter #(.DIGITS(DIGITS), .PRESCALE_W(PW)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q),
    .tc   (tc),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_mod = 1;
  int m_val = 0;
  bit m_tc  = 0;
  bit m_err = 0;
  int m_pre = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] d);
    int v;
    int dig;
    v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig = int'(d[4*k +: 4]);
      v = v * 10 + ((dig > 9) ? 0 : dig);
    end
    return v;
  endfunction

  function automatic bit load_invalid(input logic [W-1:0] d);
    for (int k = 0; k < DIGITS; k++)
      if (d[4*k +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_val = 0;
    m_tc  = 0;
    m_err = 0;
    m_pre = 0;
  endtask

  task automatic model_edge(input bit e, input bit u, input bit l, input logic [W-1:0] d);
    bit s;
    s = 0;
    if (l) begin
      m_val = load_value(d);
      m_err = load_invalid(d);
      m_tc  = 0;
      m_pre = 0;
    end else begin
      if (e) begin
`ifdef BCD_PRESCALE_EN
        if (m_pre == (1 << PW) - 1) begin
          s     = 1;
          m_pre = 0;
        end else begin
          m_pre++;
        end
`else
        s = 1;
`endif
      end
      m_tc = 0;
      if (s) begin
        if (u) begin
          if (m_val == m_mod - 1) begin m_val = 0; m_tc = 1; end
          else m_val++;
        end else begin
          if (m_val == 0) begin m_val = m_mod - 1; m_tc = 1; end
          else m_val--;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".q"},   32'(q),   32'(to_bcd(m_val)));
    check({tag, ".tc"},  32'(tc),  32'(m_tc));
    check({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  // Drive inputs (caller is at a negedge), take one rising edge, update the
  // model, then compare at the following falling edge.
  task automatic cycle(input string tag, input bit e, input bit u, input bit l,
                       input logic [W-1:0] d);
    en   = e;
    up   = u;
    load = l;
    din  = d;
    @(posedge clk);
    model_edge(e, u, l, d);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DIGITS; k++) m_mod = m_mod * 10;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b1;

    // Up wrap: 0x98 -> 0x99 -> 0x00 with tc only on the wrapped value
    cycle("upw.load", 0, 1, 1, 8'h98);
    check("upw.load_const", 32'(q), 32'h98);
`ifndef BCD_PRESCALE_EN
    cycle("upw.s1", 1, 1, 0, 8'h00);
    check("upw.s1_const", 32'({q, tc}), 32'({8'h99, 1'b0}));
    cycle("upw.s2", 1, 1, 0, 8'h00);
    check("upw.s2_const", 32'({q, tc}), 32'({8'h00, 1'b1}));
    cycle("upw.hold", 0, 1, 0, 8'h00);
    check("upw.tc_drop", 32'(tc), 32'h0);

    // Down with borrow, then down wrap from 0x00
    cycle("dn.load", 0, 0, 1, 8'h10);
    cycle("dn.s1", 1, 0, 0, 8'h00);
    check("dn.s1_const", 32'(q), 32'h09);
    cycle("dn.s2", 1, 0, 0, 8'h00);
    check("dn.s2_const", 32'(q), 32'h08);
    cycle("dn.load0", 0, 0, 1, 8'h00);
    cycle("dn.wrap", 1, 0, 0, 8'h00);
    check("dn.wrap_const", 32'({q, tc}), 32'({8'h99, 1'b1}));
    cycle("dn.after", 1, 0, 0, 8'h00);
    check("dn.after_const", 32'({q, tc}), 32'({8'h98, 1'b0}));

    // Direction flip right after a wrap: consecutive wraps give tc twice
    cycle("flip.load", 0, 1, 1, 8'h99);
    cycle("flip.w1", 1, 1, 0, 8'h00);
    cycle("flip.w2", 1, 0, 0, 8'h00);
    check("flip.w2_const", 32'({q, tc}), 32'({8'h99, 1'b1}));
`endif

    // Invalid load sets err; counting keeps it; valid load clears it
    cycle("inv.load", 0, 1, 1, 8'hA5);
    check("inv.load_const", 32'({q, err}), 32'({8'h05, 1'b1}));
    for (int i = 0; i < 5; i++) cycle("inv.step", 1, 1, 0, 8'h00);
    check("inv.sticky", 32'(err), 32'h1);
    cycle("inv.clear", 0, 1, 1, 8'h33);
    check("inv.clear_const", 32'({q, err}), 32'({8'h33, 1'b0}));
    cycle("inv.both", 0, 1, 1, 8'hFC);

    // Load wins over enable
    cycle("prio", 1, 1, 1, 8'h42);
    check("prio_const", 32'({q, tc}), 32'({8'h42, 1'b0}));

`ifdef BCD_PRESCALE_EN
    // One step per 4 enabled cycles; disabled cycles stretch the interval
    cycle("pre.load", 0, 1, 1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle("pre.run", 1, 1, 0, 8'h00);
      if (i == 2) check("pre.before1", 32'(q), 32'h00);
      if (i == 3) check("pre.at4", 32'(q), 32'h01);
      if (i == 7) check("pre.at8", 32'(q), 32'h02);
    end
    for (int i = 0; i < 3; i++) cycle("pre.hold", 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle("pre.resume", 1, 1, 0, 8'h00);
    check("pre.resume_const", 32'(q), 32'h03);
`endif

    // Reset mid-count: reach 0x47 with err set, then assert rst between edges
    cycle("mid.load", 0, 1, 1, 8'h4A);
    for (int i = 0; i < 200 && m_val != 47; i++) cycle("mid.count", 1, 1, 0, 8'h00);
    check("mid.reached", 32'({q, err}), 32'({8'h47, 1'b1}));
    en = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("mid.rst_q",   32'(q),   32'h00);
    check("mid.rst_tc",  32'(tc),  32'h0);
    check("mid.rst_err", 32'(err), 32'h0);
    @(negedge clk);
    check_state("mid.held");
    rst = 1'b1;

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      bit e, u, l;
      logic [W-1:0] d;
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0:       d = 8'h99;
        1:       d = 8'h00;
        2:       d = 8'h90;
        3:       d = 8'h09;
        default: d = W'($urandom);
      endcase
      cycle("rand", e, u, l, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter counting up or down, with synchronous parallel load, count enable, a registered wrap pulse and an invalid-load flag. It is the general-purpose decade counter for display, timer and stopwatch paths. Its wrap pulse cascades into further instances, and its digit outputs drive seven-segment decoders directly.

## Interface
- `DIGITS`, default 2: number of BCD digits; legal range 1–8.
- `PRESCALE_W`, default 23: prescaler width; used only when `BCD_PRESCALE_EN` is defined.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `en` input 1: count enable, sampled on `clk`.
- `up` input 1: direction; 1 = up, 0 = down; sampled on every step.
- `load` input 1: synchronous parallel load.
- `din` input 4*DIGITS: load value; digit 0 is in bits [3:0].
- `q` output 4*DIGITS: counter value, registered; digit k is in bits [4k+3:4k].
- `tc` output 1: registered wrap pulse.
- `err` output 1: sticky invalid-load flag, registered.

## Operation
- Reset (`rst` low, asynchronous): `q` = 0, `tc` = 0, `err` = 0, prescaler = 0. Release is taken on the next `clk` edge; the first step can occur no earlier than that edge.
- Priority at each edge: `load` > step > hold.
- Load:
  - Each digit of `din` with value ≤ 9 is copied into `q`.
  - Each digit > 9 is written as 0.
  - `err` is set if any digit was > 9 and cleared otherwise.
  - `tc` is 0 in the cycle after a load.
  - The prescaler is cleared.
- Step condition:
  - Without the macro: `en` = 1 and `load` = 0.
  - With the macro: `en` = 1, `load` = 0 and prescaler all-ones.
- Up step:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - If all digits are 9, `q` becomes all 0 and `tc` = 1 in the following cycle.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - If all digits are 0, `q` becomes all 9 and `tc` = 1 in the following cycle.
- `tc` is 0 on every edge that does not perform a wrapping step. It is never high for two consecutive cycles unless consecutive steps both wrap, which is only possible when the direction flips.
- `err` is cleared only by reset or by a load with all digits valid. Counting does not affect it.
- `q` never holds a digit > 9 at any time.
- Direction change takes effect on the step where `up` is sampled. There is no pipeline and no history.

## Timing
- Latency: `q` reflects a step or load on the edge at which the step condition or `load` was sampled.
- `tc` is asserted on the same edge as the wrapped `q` value and lasts exactly one cycle.
- `tc` from instance N drives `en` of instance N+1, with the same `up` on both instances. The cascade then advances the higher instance in the cycle after the wrap.
- No combinational path exists from any input to any output.

## Configuration
- `BCD_PRESCALE_EN` defined:
  - An internal `PRESCALE_W`-bit prescaler increments on every edge where `en` = 1 and `load` = 0.
  - It holds when `en` = 0 and clears on load.
  - A step occurs only when the prescaler is all-ones (it then wraps to 0), i.e. one step per 2^`PRESCALE_W` enabled cycles.
- `BCD_PRESCALE_EN` undefined:
  - There is no prescaler and `PRESCALE_W` is ignored.
  - Every enabled, non-load edge is a step.

## Test plan
- Reset mid-count: count to `q` = 0x47, assert `rst` low between edges → `q` = 0x00, `tc` = 0, `err` = 0 immediately, without waiting for a clock edge.
- Up wrap (DIGITS=2): load 0x98, `up` = 1, `en` = 1 for 2 cycles → `q` = 0x99 then 0x00; `tc` = 1 only in the 0x00 cycle.
- Down wrap with borrow: load 0x10, `up` = 0, 2 steps → 0x09, then 0x08; load 0x00 and step once → 0x99 with a one-cycle `tc`.
- Invalid load: `din` = 0xA5 → `q` = 0x05, `err` = 1; 5 up-steps → `err` stays 1; load 0x33 → `err` = 0.
- Load priority: `load` = 1 with `en` = 1, `din` = 0x42 → `q` = 0x42, no step, `tc` = 0.
- Prescale (macro defined, `PRESCALE_W` = 2): `en` high for 8 cycles from `q` = 0 → `q` steps to 1 on the 4th edge and to 2 on the 8th; dropping `en` for 3 cycles delays the next step by exactly 3 cycles.
